conv_window_feeder: RTL

- Upstream neighbour of Convolution_Controller. Takes a raster-order pixel AXI4-Stream (full image, row by row) from DMA.
- Uses two internal line buffers to re-order the stream into the column-triple order the controller's 3x3 kernel expects: top, mid, bottom of each column.
- Output for each row r >= 2: 3*W beats. The controller therefore sees 9 beats to prime its first window of a line, then 3 beats per column shift.

---
 rtl/conv_window_feeder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Re-orders a raster-order pixel stream into column triples (top, mid,
//   bottom) for a downstream 3x3 convolution controller. Rows 0-1 prime two
//   line buffers. Every later pixel produces three output beats: the pixels
//   two rows up, one row up, and the pixel itself, all in the same column.
//
// Ports
//   axi_clk, axi_reset_n      clock, asynchronous active-low reset
//   enable                    frame may start only while high
//   cfg_width, cfg_height     image size, latched at frame start
//   s_axis_*                  raster-order pixel input (last = final pixel)
//   m_axis_*                  column-triple output (last = final beat of frame)
//   busy                      high outside IDLE
//   cfg_err                   sticky: frame start refused for illegal size
//   frame_err                 sticky: s_axis_last disagreed with frame length
module conv_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WIDTH  = 1024,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  enable,
    input  logic [DIM_WIDTH-1:0]  cfg_width,
    input  logic [DIM_WIDTH-1:0]  cfg_height,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [3:0]            m_axis_keep,
    output logic                  busy,
    output logic                  cfg_err,
    output logic                  frame_err
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [DIM_WIDTH-1:0] ONE   = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] THREE = DIM_WIDTH'(3);
    localparam logic [DIM_WIDTH:0]   MAX_W = (DIM_WIDTH+1)'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, PRIME, ACCEPT, EMIT} state_t;

    state_t                state, state_nx;
    logic [DIM_WIDTH-1:0]  w_lat, h_lat, row, col;
    logic [1:0]            beat;
    logic [DATA_WIDTH-1:0] t_q, m_q, b_q;
    logic [DATA_WIDTH-1:0] lb_top [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] lb_mid [MAX_WIDTH];

    logic          s_fire, m_fire, cfg_ok, at_row_end, at_final, beat_end;
    logic [AW-1:0] col_idx;

    assign col_idx    = col[AW-1:0];
    assign cfg_ok     = (cfg_width >= THREE) && ({1'b0, cfg_width} <= MAX_W) &&
                        (cfg_height >= THREE);
    assign at_row_end = (col == w_lat - ONE);
    assign at_final   = at_row_end && (row == h_lat - ONE);
    assign beat_end   = (beat == 2'd2);
    assign s_fire     = s_axis_valid && s_axis_ready;
    assign m_fire     = m_axis_valid && m_axis_ready;

    // State register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else              state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (enable && cfg_ok) state_nx = PRIME;
            // s_axis_last can never be legal while priming (H >= 3)
            PRIME:  if (s_fire) begin
                        if (s_axis_last)                             state_nx = IDLE;
                        else if (row == ONE && at_row_end)           state_nx = ACCEPT;
                    end
            // Early last aborts without emitting the offending pixel's column
            ACCEPT: if (s_fire) state_nx = (s_axis_last && !at_final) ? IDLE : EMIT;
            EMIT:   if (m_fire && beat_end) state_nx = at_final ? IDLE : ACCEPT;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_axis_ready = (state == PRIME) || (state == ACCEPT);
        m_axis_valid = (state == EMIT);
        busy         = (state != IDLE);
        m_axis_keep  = m_axis_valid ? 4'hf : 4'h0;
        m_axis_last  = m_axis_valid && beat_end && at_final;
        m_axis_data  = '0;
        if (m_axis_valid) begin
            unique case (beat)
                2'd0:    m_axis_data = t_q;
                2'd1:    m_axis_data = m_q;
                default: m_axis_data = b_q;
            endcase
        end
    end

    // Counters, size latch and sticky errors
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            w_lat     <= '0;
            h_lat     <= '0;
            row       <= '0;
            col       <= '0;
            beat      <= '0;
            cfg_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (enable) begin
                    w_lat <= cfg_width;
                    h_lat <= cfg_height;
                    row   <= '0;
                    col   <= '0;
                    if (!cfg_ok) cfg_err <= 1'b1;
                end
                PRIME: if (s_fire) begin
                    if (s_axis_last) frame_err <= 1'b1;
                    if (at_row_end) begin
                        col <= '0;
                        row <= row + ONE;
                    end else begin
                        col <= col + ONE;
                    end
                end
                ACCEPT: if (s_fire) begin
                    beat <= '0;
                    if (s_axis_last != at_final) frame_err <= 1'b1;
                end
                EMIT: if (m_fire) begin
                    if (beat_end) begin
                        beat <= '0;
                        if (at_row_end) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffers: read-before-write on the same column. On each accept in
    // ACCEPT the column shifts up one row (mid->top, pixel->mid) while the old
    // contents are captured as the top/mid beats of the triple.
    always_ff @(posedge axi_clk) begin
        if (s_fire && state == PRIME) begin
            if (row == '0) lb_top[col_idx] <= s_axis_data;
            else           lb_mid[col_idx] <= s_axis_data;
        end
        if (s_fire && state == ACCEPT) begin
            t_q             <= lb_top[col_idx];
            m_q             <= lb_mid[col_idx];
            b_q             <= s_axis_data;
            lb_top[col_idx] <= lb_mid[col_idx];
            lb_mid[col_idx] <= s_axis_data;
        end
    end

endmodule
